// File: rtl/reaction_game_core.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_game_core
//  Description : Reaction-time game engine clocked by the 1 kHz game tick.
//                A start edge with all switches low draws a random delay and
//                a random target channel from a free-running LFSR. When the
//                delay expires, one LED is lit. The engine then counts ms in
//                BCD until the matching switch is raised and keeps the best
//                (lowest) valid time. False starts, wrong switches, an
//                impossible zero-time reaction and a saturated counter all
//                end the round in FAULT.
//  Ports       : Clk_1K      - game tick, rising edge
//                Rst_n       - asynchronous active-low reset
//                start_i     - start button level (edge detected inside)
//                clr_best_i  - synchronous clear of the best score
//                sw_i        - player switches, already synchronised
//                led_o       - one-hot target LED
//                state_o     - FSM state (IDLE=0 WAIT=1 REACT=2 DONE=3 FAULT=4)
//                score_bcd_o - current reaction time, BCD
//                best_bcd_o  - best valid reaction time, BCD
//                new_best_o  - one-cycle pulse when best is updated
//                fault_o     - high while in FAULT
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_game_core #(
  parameter int N_CH    = 10,
  parameter int LFSR_W  = 16,
  parameter int DLY_W   = 11,
  parameter int MIN_DLY = 1000,
  parameter int DIGITS  = 5
) (
  input  logic                  Clk_1K,
  input  logic                  Rst_n,
  input  logic                  start_i,
  input  logic                  clr_best_i,
  input  logic [N_CH-1:0]       sw_i,
  output logic [N_CH-1:0]       led_o,
  output logic [2:0]            state_o,
  output logic [4*DIGITS-1:0]   score_bcd_o,
  output logic [4*DIGITS-1:0]   best_bcd_o,
  output logic                  new_best_o,
  output logic                  fault_o
);

  localparam int TGT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(MIN_DLY + (1 << DLY_W));
  localparam int BCD_W = 4 * DIGITS;

  // Fibonacci tap masks (bit k-1 set for tap k). Widths without a table
  // entry use the top two bits, which keeps the register invertible so a
  // non-zero seed can never reach the all-zero lock-up state.
  function automatic logic [LFSR_W-1:0] lfsr_taps();
    logic [63:0] m;
    case (LFSR_W)
      8:       m = 64'h0000_0000_0000_00B8;   // 8,6,5,4
      16:      m = 64'h0000_0000_0000_B400;   // 16,14,13,11
      24:      m = 64'h0000_0000_00E1_0000;   // 24,23,22,17
      32:      m = 64'h0000_0000_8020_0003;   // 32,22,2,1
      default: m = 64'd3 << (LFSR_W - 2);
    endcase
    return m[LFSR_W-1:0];
  endfunction

  localparam logic [LFSR_W-1:0] c_taps      = lfsr_taps();
  localparam logic [BCD_W-1:0]  c_all_nines = {DIGITS{4'h9}};
  localparam logic [N_CH-1:0]   c_one       = N_CH'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_REACT = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t              r_state;
  logic [LFSR_W-1:0]   r_lfsr;
  logic                r_start_d;
  logic [CNT_W-1:0]    r_dly;
  logic [TGT_W-1:0]    r_tgt;
  logic [N_CH-1:0]     r_led;
  logic [BCD_W-1:0]    r_score;
  logic [BCD_W-1:0]    r_best;
  logic                r_new_best;
  logic                r_fault;
  logic                r_done_entry;   // first cycle spent in DONE

  logic                w_start_edge;
  logic                w_sw_idle;
  logic                w_tgt_hit;
  logic                w_other_hit;
  logic                w_score_zero;
  logic                w_score_max;
  logic                w_lfsr_fb;
  logic [CNT_W-1:0]    w_dly_seed;
  logic [TGT_W-1:0]    w_tgt_seed;
  logic [BCD_W-1:0]    w_score_inc;
  logic                w_carry;

  assign w_start_edge = start_i & ~r_start_d;
  assign w_sw_idle    = (sw_i == '0);
  assign w_tgt_hit    = sw_i[r_tgt];
  assign w_other_hit  = |(sw_i & ~(c_one << r_tgt));
  assign w_score_zero = (r_score == '0);
  assign w_score_max  = (r_score == c_all_nines);
  assign w_lfsr_fb    = ^(r_lfsr & c_taps);
  assign w_dly_seed   = CNT_W'(MIN_DLY) + CNT_W'(r_lfsr[DLY_W-1:0]);
  assign w_tgt_seed   = TGT_W'(32'(r_lfsr[LFSR_W-1 -: 8]) % N_CH);

  // Ripple BCD increment: a digit only moves while the carry is still set.
  always_comb begin
    w_score_inc = r_score;
    w_carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk_1K or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= ST_IDLE;
      r_lfsr       <= LFSR_W'(1);
      r_start_d    <= 1'b1;     // a button held through reset is not a start
      r_dly        <= '0;
      r_tgt        <= '0;
      r_led        <= '0;
      r_score      <= '0;
      r_best       <= c_all_nines;
      r_new_best   <= 1'b0;
      r_fault      <= 1'b0;
      r_done_entry <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[LFSR_W-2:0], w_lfsr_fb};
      r_start_d    <= start_i;
      r_new_best   <= 1'b0;
      r_done_entry <= 1'b0;

      // Best-score bookkeeping runs beside the state case so that a start
      // edge in the DONE entry cycle still records the finished round.
      // BCD digits order the same way as binary, so a plain compare works.
      if (clr_best_i) begin
        r_best <= c_all_nines;
      end else if (r_state == ST_DONE && r_done_entry && r_score < r_best) begin
        r_best     <= r_score;
        r_new_best <= 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          r_led <= '0;
          if (w_start_edge && w_sw_idle) begin
            r_state <= ST_WAIT;
            r_dly   <= w_dly_seed;
            r_tgt   <= w_tgt_seed;
            r_score <= '0;
            r_fault <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (!w_sw_idle) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_led   <= '0;
          end else if (r_dly <= CNT_W'(1)) begin
            r_state <= ST_REACT;
            r_led   <= c_one << r_tgt;
          end else begin
            r_dly <= r_dly - CNT_W'(1);
          end
        end
        ST_REACT: begin
          if (w_tgt_hit && !w_other_hit && !w_score_zero) begin
            r_state      <= ST_DONE;
            r_done_entry <= 1'b1;
            r_led        <= '0;
          end else if ((w_tgt_hit && w_score_zero) || w_other_hit || w_score_max) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_led   <= '0;
          end else begin
            r_score <= w_score_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_led   <= '0;
        end
      endcase
    end
  end

  assign led_o       = r_led;
  assign state_o     = r_state;
  assign score_bcd_o = r_score;
  assign best_bcd_o  = r_best;
  assign new_best_o  = r_new_best;
  assign fault_o     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_reaction_game_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_game_core
//  Description : Self-checking bench for reaction_game_core. Three-digit BCD
//                keeps the saturation round short; all other parameters are
//                the defaults. Directed rounds come from a vector table,
//                followed by randomized rounds checked against a round-level
//                model, then reset and ignored-start sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_game_core;

  localparam int N_CH   = 10;
  localparam int DIGITS = 3;
  localparam int MAXV   = 999;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_REACT = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam int M_VALID   = 0;  // target switch after k ticks (k=0: too fast)
  localparam int M_WRONG   = 1;  // non-target switch after k ticks
  localparam int M_FALSE   = 2;  // switch during the random delay
  localparam int M_TIMEOUT = 3;  // never respond

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  start = 1'b0;
  logic                  clr_best = 1'b0;
  logic [N_CH-1:0]       sw = '0;
  logic [N_CH-1:0]       led;
  logic [2:0]            state;
  logic [4*DIGITS-1:0]   score;
  logic [4*DIGITS-1:0]   best;
  logic                  new_best;
  logic                  fault;

  reaction_game_core #(
    .N_CH(N_CH), .LFSR_W(16), .DLY_W(11), .MIN_DLY(1000), .DIGITS(DIGITS)
  ) dut (
    .Clk_1K(clk), .Rst_n(rst_n), .start_i(start), .clr_best_i(clr_best),
    .sw_i(sw), .led_o(led), .state_o(state), .score_bcd_o(score),
    .best_bcd_o(best), .new_best_o(new_best), .fault_o(fault)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, seeded with 1 by reset.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'd1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int n_chk = 0;
  int n_err = 0;
  int m_best = MAXV;

  typedef struct {
    int         mode;
    int         k;
    bit         clr;
    logic [11:0] e_score;
    logic [11:0] e_best;
    bit         e_nb;
    bit         e_fault;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-level model: outcome of one round from the game rules alone.
  task automatic model(input int mode, input int k, input bit clr,
                       output logic [11:0] e_score, output logic [11:0] e_best,
                       output bit e_nb, output bit e_fault);
    int nb_val;
    nb_val  = m_best;
    e_nb    = 1'b0;
    e_fault = 1'b1;
    e_score = to_bcd(0);
    if (mode == M_VALID && k > 0) begin
      e_fault = 1'b0;
      e_score = to_bcd(k);
      if (!clr && k < m_best) begin
        nb_val = k;
        e_nb   = 1'b1;
      end
    end else if (mode == M_WRONG) begin
      e_score = to_bcd(k);
    end else if (mode == M_TIMEOUT) begin
      e_score = to_bcd(MAXV);
    end
    if (clr) nb_val = MAXV;
    m_best = nb_val;
    e_best = to_bcd(nb_val);
  endtask

  task automatic run_round(input string tag, input int mode, input int k, input bit clr,
                           input int off, input logic [11:0] e_score,
                           input logic [11:0] e_best, input bit e_nb, input bit e_fault);
    int dly_m, tgt_m, n;
    sw = '0; clr_best = 1'b0; start = 1'b0;
    tick();
    dly_m = 1000 + int'(m_lfsr[10:0]);
    tgt_m = int'(m_lfsr[15:8]) % N_CH;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".wait_state"}, state, ST_WAIT);
    if (mode == M_FALSE) begin
      repeat (k) tick();
      sw = 10'd1 << off;
      tick();
    end else begin
      n = 0;
      while (led == '0 && n < 4000) begin
        tick();
        n++;
      end
      check({tag, ".dly"}, n, dly_m);
      check({tag, ".dly_range"}, (n >= 1000 && n <= 3047), 1);
      check({tag, ".led"}, led, 10'd1 << tgt_m);
      check({tag, ".react_state"}, state, ST_REACT);
      if (mode == M_TIMEOUT) begin
        repeat (MAXV) tick();
        check({tag, ".sat_state"}, state, ST_REACT);
        check({tag, ".sat_score"}, score, to_bcd(MAXV));
        tick();
      end else begin
        repeat (k) tick();
        sw = (mode == M_VALID) ? (10'd1 << tgt_m) : (10'd1 << ((tgt_m + 1 + off) % N_CH));
        tick();
      end
    end
    check({tag, ".end_state"}, state, e_fault ? ST_FAULT : ST_DONE);
    check({tag, ".fault"}, fault, e_fault);
    check({tag, ".score"}, score, e_score);
    clr_best = clr;
    tick();
    clr_best = 1'b0;
    check({tag, ".best"}, best, e_best);
    check({tag, ".new_best"}, new_best, e_nb);
    tick();
    check({tag, ".nb_drop"}, new_best, 0);
    check({tag, ".led_off"}, led, 0);
    check({tag, ".score_held"}, score, e_score);
    sw = '0;
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] es, eb;
    bit enb, ef;
    int mode, k, off;
    bit clr;

    tbl[0] = '{M_VALID,   237, 1'b0, 12'h237, 12'h237, 1'b1, 1'b0};
    tbl[1] = '{M_VALID,   412, 1'b0, 12'h412, 12'h237, 1'b0, 1'b0};
    tbl[2] = '{M_FALSE,    10, 1'b0, 12'h000, 12'h237, 1'b0, 1'b1};
    tbl[3] = '{M_WRONG,    50, 1'b0, 12'h050, 12'h237, 1'b0, 1'b1};
    tbl[4] = '{M_VALID,   100, 1'b1, 12'h100, 12'h999, 1'b0, 1'b0};
    tbl[5] = '{M_VALID,   998, 1'b0, 12'h998, 12'h998, 1'b1, 1'b0};
    tbl[6] = '{M_VALID,     1, 1'b0, 12'h001, 12'h001, 1'b1, 1'b0};
    tbl[7] = '{M_VALID,     0, 1'b0, 12'h000, 12'h001, 1'b0, 1'b1};
    tbl[8] = '{M_VALID,     1, 1'b0, 12'h001, 12'h001, 1'b0, 1'b0};
    tbl[9] = '{M_TIMEOUT,   0, 1'b0, 12'h999, 12'h001, 1'b0, 1'b1};

    #1 rst_n = 1'b0;
    #1;
    check("rst.state", state, ST_IDLE);
    check("rst.led", led, 0);
    check("rst.score", score, 0);
    check("rst.best", best, 12'h999);
    check("rst.new_best", new_best, 0);
    check("rst.fault", fault, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("idle.state", state, ST_IDLE);

    for (int i = 0; i < 10; i++) begin
      model(tbl[i].mode, tbl[i].k, tbl[i].clr, es, eb, enb, ef);
      run_round($sformatf("vec%0d", i), tbl[i].mode, tbl[i].k, tbl[i].clr, 0,
                tbl[i].e_score, tbl[i].e_best, tbl[i].e_nb, tbl[i].e_fault);
    end

    // Start edge while a switch is up is ignored in FAULT.
    sw = 10'h001;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_start.state", state, ST_FAULT);
    check("ign_start.fault", fault, 1);
    sw = '0;
    tick();
    check("ign_start.stay", state, ST_FAULT);

    for (int r = 0; r < 6; r++) begin
      mode = $urandom_range(0, 2);
      k    = $urandom_range(0, 300);
      clr  = ($urandom_range(0, 3) == 0);
      off  = $urandom_range(0, 8);
      model(mode, k, clr, es, eb, enb, ef);
      run_round($sformatf("rnd%0d", r), mode, k, clr, off, es, eb, enb, ef);
    end

    // Reset asserted mid-REACT clears everything, including best.
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 4000 && led == '0; n++) tick();
    repeat (20) tick();
    check("midrst.pre_state", state, ST_REACT);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.state", state, ST_IDLE);
    check("midrst.led", led, 0);
    check("midrst.score", score, 0);
    check("midrst.best", best, 12'h999);
    check("midrst.new_best", new_best, 0);
    check("midrst.fault", fault, 0);
    @(negedge clk) rst_n = 1'b1;
    m_best = MAXV;
    model(M_VALID, 5, 1'b0, es, eb, enb, ef);
    run_round("post_rst", M_VALID, 5, 1'b0, 0, es, eb, enb, ef);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
